rf_black_widow_alu_issue: RTL and testbench

RF_BLACK_WIDOW_ALU_ISSUE -- requirements
Module: rf_black_widow_alu_issue

---
 rtl/rf_black_widow_alu_issue_pkg.sv | 65 ++++++
 rtl/rf_black_widow_alu_issue_sel.sv | 30 +++
 rtl/rf_black_widow_alu_issue.sv | 215 +++++++++++++++++++++
 tb/tb_rf_black_widow_alu_issue.sv | 395 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_black_widow_alu_issue_pkg.sv
// Shared types for the Black Widow ALU issue queue: operand/tag widths, the queue entry record,
// and the operand set handed to the ALU.
package rfBlackWidowPkg;

   localparam int BW_NENT  = 4;
   localparam int BW_TAGW  = 5;
   localparam int BW_INSTW = 32;
   localparam int BW_ADDRW = 64;
   localparam int BW_VALW  = 80;
   // Ages are a dense rank 0..NENT-1, so three bits cover the largest queue.
   localparam int BW_AGEW  = 3;

   typedef logic [BW_INSTW-1:0] Instruction;
   typedef logic [BW_ADDRW-1:0] Address;
   typedef logic [BW_VALW-1:0]  Value;
   typedef logic [BW_TAGW-1:0]  Tag;
   typedef logic [BW_AGEW-1:0]  Age;

   typedef struct packed {
      logic       v;
      Instruction ir;
      Address     ip;
      Value       imm;
      Tag         tgt;
      logic       av;
      Tag         at;
      Value       a;
      logic       bv;
      Tag         bt;
      Value       b;
      logic       cv;
      Tag         ct;
      Value       c;
      Age         age;
   } IssueEntry;

   typedef struct packed {
      Instruction ir;
      Address     ip;
      Value       imm;
      Tag         tgt;
      Value       a;
      Value       b;
      Value       c;
   } IssueOp;

   // A waiting operand captures the result bus when the broadcast tag matches its producer.
   function automatic logic tag_hit(input logic rb_v, input Tag rb_tag,
                                    input logic op_v, input Tag op_t);
      return rb_v && !op_v && (rb_tag == op_t);
   endfunction

   function automatic IssueOp entry_op(input IssueEntry e);
      IssueOp op;
      op.ir  = e.ir;
      op.ip  = e.ip;
      op.imm = e.imm;
      op.tgt = e.tgt;
      op.a   = e.a;
      op.b   = e.b;
      op.c   = e.c;
      return op;
   endfunction

endpackage

// File: rtl/rf_black_widow_alu_issue_sel.sv
// Oldest-ready picker: grants the ready entry with the smallest age rank, lowest index on a tie.
module rf_black_widow_issue_sel
   import rfBlackWidowPkg::*;
#(
   parameter int NENT = BW_NENT,
   parameter int AGEW = BW_AGEW
) (
   input  logic [NENT-1:0]           i_ready,
   input  logic [NENT-1:0][AGEW-1:0] i_age,
   output logic [NENT-1:0]           o_grant
);

   genvar gi, gj;
   generate
      for (gi = 0; gi < NENT; gi++) begin : g_row
         logic [NENT-1:0] w_beat;
         for (gj = 0; gj < NENT; gj++) begin : g_col
            if (gj == gi) begin : g_self
               assign w_beat[gj] = 1'b0;
            end else if (gj < gi) begin : g_lower
               assign w_beat[gj] = i_ready[gj] && (i_age[gj] <= i_age[gi]);
            end else begin : g_upper
               assign w_beat[gj] = i_ready[gj] && (i_age[gj] < i_age[gi]);
            end
         end
         assign o_grant[gi] = i_ready[gi] && !(|w_beat);
      end
   endgenerate

endmodule

// File: rtl/rf_black_widow_alu_issue.sv
// Black Widow ALU issue queue: dispatch, result-bus wakeup, oldest-ready issue with stall hold.
// Optional zero-latency dispatch bypass is enabled by defining BW_ISSUE_BYPASS_EN.
module rf_black_widow_alu_issue
   import rfBlackWidowPkg::*;
#(
   parameter int NENT = BW_NENT,
   parameter int TAGW = BW_TAGW
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                flush,
   input  logic                disp_v,
   output logic                disp_rdy,
   input  logic [BW_INSTW-1:0] disp_ir,
   input  logic [BW_ADDRW-1:0] disp_ip,
   input  logic [BW_VALW-1:0]  disp_imm,
   input  logic [TAGW-1:0]     disp_tgt,
   input  logic                disp_av,
   input  logic                disp_bv,
   input  logic                disp_cv,
   input  logic [TAGW-1:0]     disp_at,
   input  logic [TAGW-1:0]     disp_bt,
   input  logic [TAGW-1:0]     disp_ct,
   input  logic [BW_VALW-1:0]  disp_a,
   input  logic [BW_VALW-1:0]  disp_b,
   input  logic [BW_VALW-1:0]  disp_c,
   input  logic                rb_v,
   input  logic [TAGW-1:0]     rb_tag,
   input  logic [BW_VALW-1:0]  rb_val,
   output logic                iss_v,
   input  logic                iss_rdy,
   output logic [BW_INSTW-1:0] iss_ir,
   output logic [BW_ADDRW-1:0] iss_ip,
   output logic [BW_VALW-1:0]  iss_a,
   output logic [BW_VALW-1:0]  iss_b,
   output logic [BW_VALW-1:0]  iss_c,
   output logic [BW_VALW-1:0]  iss_imm,
   output logic [TAGW-1:0]     iss_tgt
);

   IssueEntry r_ent      [NENT];
   IssueEntry w_ent_next [NENT];
   logic            r_hold_v;
   logic [NENT-1:0] r_hold_oh;

   logic [NENT-1:0]              w_ready;
   logic [NENT-1:0][BW_AGEW-1:0] w_age;
   logic [NENT-1:0]              w_grant;
   logic [NENT-1:0]              w_sel_oh;
   logic [NENT-1:0]              w_wr_oh;
   logic [NENT-1:0]              w_free_oh;
   logic                         w_any_free;
   logic                         w_q_v;
   logic                         w_free_v;
   Age                           w_new_age;
   Age                           w_free_age;
   logic                         w_hit_a, w_hit_b, w_hit_c;
   logic                         w_disp_all_v;
   logic                         w_disp_ok;
   logic                         w_byp;
   logic                         w_accept;
   logic                         w_write;
   IssueOp                       w_disp_op;
   IssueEntry                    w_disp;
   IssueOp                       w_op;

   genvar gi;
   generate
      for (gi = 0; gi < NENT; gi++) begin : g_ent
         assign w_ready[gi] = r_ent[gi].v && r_ent[gi].av && r_ent[gi].bv && r_ent[gi].cv;
         assign w_age[gi]   = r_ent[gi].age;
      end
   endgenerate

   rf_black_widow_issue_sel #(
      .NENT (NENT),
      .AGEW (BW_AGEW)
   ) u_sel (
      .i_ready (w_ready),
      .i_age   (w_age),
      .o_grant (w_grant)
   );

   // A stalled selection is pinned until the ALU takes it, even if an older entry wakes.
   assign w_sel_oh = r_hold_v ? r_hold_oh : w_grant;
   assign w_q_v    = |w_sel_oh;

   always_comb begin
      w_wr_oh    = '0;
      w_any_free = 1'b0;
      for (int i = 0; i < NENT; i++) begin
         if (!r_ent[i].v && !w_any_free) begin
            w_wr_oh[i] = 1'b1;
            w_any_free = 1'b1;
         end
      end
   end

   assign w_hit_a      = tag_hit(rb_v, rb_tag, disp_av, disp_at);
   assign w_hit_b      = tag_hit(rb_v, rb_tag, disp_bv, disp_bt);
   assign w_hit_c      = tag_hit(rb_v, rb_tag, disp_cv, disp_ct);
   assign w_disp_all_v = (disp_av || w_hit_a) && (disp_bv || w_hit_b) && (disp_cv || w_hit_c);
   assign w_disp_ok    = disp_v && w_any_free && !flush && !rst;

`ifdef BW_ISSUE_BYPASS_EN
   assign w_byp = w_disp_ok && !(|w_ready) && w_disp_all_v;
`else
   assign w_byp = 1'b0;
`endif

   assign disp_rdy  = !rst && w_any_free;
   assign iss_v     = !rst && (w_q_v || w_byp);
   assign w_accept  = iss_v && iss_rdy;
   assign w_free_oh = (w_accept && !w_byp) ? w_sel_oh : '0;
   assign w_free_v  = |w_free_oh;
   assign w_write   = w_disp_ok && !(w_byp && iss_rdy);

   // New entries rank behind every survivor; survivors younger than the freed one close the gap.
   always_comb begin
      w_new_age  = '0;
      w_free_age = '0;
      for (int i = 0; i < NENT; i++) begin
         if (r_ent[i].v && !w_free_oh[i]) w_new_age = w_new_age + Age'(1);
         if (w_free_oh[i]) w_free_age = w_free_age | r_ent[i].age;
      end
   end

   always_comb begin
      w_disp_op.ir  = disp_ir;
      w_disp_op.ip  = disp_ip;
      w_disp_op.imm = disp_imm;
      w_disp_op.tgt = disp_tgt;
      w_disp_op.a   = w_hit_a ? rb_val : disp_a;
      w_disp_op.b   = w_hit_b ? rb_val : disp_b;
      w_disp_op.c   = w_hit_c ? rb_val : disp_c;
   end

   always_comb begin
      w_disp     = '0;
      w_disp.v   = 1'b1;
      w_disp.ir  = w_disp_op.ir;
      w_disp.ip  = w_disp_op.ip;
      w_disp.imm = w_disp_op.imm;
      w_disp.tgt = w_disp_op.tgt;
      w_disp.av  = disp_av || w_hit_a;
      w_disp.at  = disp_at;
      w_disp.a   = w_disp_op.a;
      w_disp.bv  = disp_bv || w_hit_b;
      w_disp.bt  = disp_bt;
      w_disp.b   = w_disp_op.b;
      w_disp.cv  = disp_cv || w_hit_c;
      w_disp.ct  = disp_ct;
      w_disp.c   = w_disp_op.c;
      w_disp.age = w_new_age;
   end

   always_comb begin
      w_op = '0;
      if (w_byp) begin
         w_op = w_disp_op;
      end else begin
         for (int i = 0; i < NENT; i++) begin
            if (w_sel_oh[i]) w_op = w_op | entry_op(r_ent[i]);
         end
      end
      if (rst) w_op = '0;
   end

   assign iss_ir  = w_op.ir;
   assign iss_ip  = w_op.ip;
   assign iss_a   = w_op.a;
   assign iss_b   = w_op.b;
   assign iss_c   = w_op.c;
   assign iss_imm = w_op.imm;
   assign iss_tgt = w_op.tgt;

   always_comb begin
      for (int i = 0; i < NENT; i++) begin
         w_ent_next[i] = r_ent[i];
         if (w_free_oh[i]) begin
            w_ent_next[i].v = 1'b0;
         end else if (w_free_v && (r_ent[i].age > w_free_age)) begin
            w_ent_next[i].age = r_ent[i].age - Age'(1);
         end
         if (tag_hit(rb_v, rb_tag, r_ent[i].av, r_ent[i].at)) begin
            w_ent_next[i].av = 1'b1;
            w_ent_next[i].a  = rb_val;
         end
         if (tag_hit(rb_v, rb_tag, r_ent[i].bv, r_ent[i].bt)) begin
            w_ent_next[i].bv = 1'b1;
            w_ent_next[i].b  = rb_val;
         end
         if (tag_hit(rb_v, rb_tag, r_ent[i].cv, r_ent[i].ct)) begin
            w_ent_next[i].cv = 1'b1;
            w_ent_next[i].c  = rb_val;
         end
         if (w_write && w_wr_oh[i]) w_ent_next[i] = w_disp;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         for (int i = 0; i < NENT; i++) r_ent[i] <= '0;
         r_hold_v  <= 1'b0;
         r_hold_oh <= '0;
      end else begin
         for (int i = 0; i < NENT; i++) r_ent[i] <= w_ent_next[i];
         r_hold_v <= iss_v && !iss_rdy;
         // A stalled bypass op lands in its write slot, so that slot becomes the pinned one.
         if (iss_v && !iss_rdy) r_hold_oh <= w_byp ? w_wr_oh : w_sel_oh;
         else                   r_hold_oh <= '0;
      end
   end

endmodule

// File: tb/tb_rf_black_widow_alu_issue.sv
// Self-checking bench for rf_black_widow_alu_issue: vector table, directed corner sequences,
// and a randomized run against an in-order queue model. Follows BW_ISSUE_BYPASS_EN if defined.
module tb_rf_black_widow_alu_issue;
   import rfBlackWidowPkg::*;

   localparam int NENT = 4;
   localparam int TAGW = 5;
   localparam logic [31:0] OP_ADDI = 32'h13;
   localparam logic [31:0] OP_ADD  = 32'h33;

   logic clk = 1'b0;
   logic rst, flush, disp_v, disp_rdy;
   logic [31:0] disp_ir, iss_ir;
   logic [63:0] disp_ip, iss_ip;
   logic [79:0] disp_imm, disp_a, disp_b, disp_c, rb_val;
   logic [79:0] iss_a, iss_b, iss_c, iss_imm;
   logic [TAGW-1:0] disp_tgt, disp_at, disp_bt, disp_ct, rb_tag, iss_tgt;
   logic disp_av, disp_bv, disp_cv, rb_v, iss_v, iss_rdy;

   always #5 clk = ~clk;

   rf_black_widow_alu_issue #(.NENT(NENT), .TAGW(TAGW)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .disp_v(disp_v), .disp_rdy(disp_rdy),
      .disp_ir(disp_ir), .disp_ip(disp_ip), .disp_imm(disp_imm), .disp_tgt(disp_tgt),
      .disp_av(disp_av), .disp_bv(disp_bv), .disp_cv(disp_cv),
      .disp_at(disp_at), .disp_bt(disp_bt), .disp_ct(disp_ct),
      .disp_a(disp_a), .disp_b(disp_b), .disp_c(disp_c),
      .rb_v(rb_v), .rb_tag(rb_tag), .rb_val(rb_val),
      .iss_v(iss_v), .iss_rdy(iss_rdy),
      .iss_ir(iss_ir), .iss_ip(iss_ip), .iss_a(iss_a), .iss_b(iss_b), .iss_c(iss_c),
      .iss_imm(iss_imm), .iss_tgt(iss_tgt)
   );

   typedef struct packed {
      logic [31:0] ir;
      logic [63:0] ip;
      logic [79:0] imm;
      logic [4:0]  tgt;
      logic        av;
      logic [4:0]  at;
      logic [79:0] a;
      logic        bv;
      logic [4:0]  bt;
      logic [79:0] b;
      logic        cv;
      logic [4:0]  ct;
      logic [79:0] c;
   } disp_t;

   typedef struct packed {
      disp_t       d;
      logic [79:0] exp_res;
   } vec_t;

   // Model entry: operands as small arrays, plus a flag for "stalled on the ALU port".
   typedef struct packed {
      logic [31:0]       ir;
      logic [63:0]       ip;
      logic [79:0]       imm;
      logic [4:0]        tgt;
      logic [2:0]        ov;
      logic [2:0][4:0]   ot;
      logic [2:0][79:0]  val;
      logic              held;
   } mop_t;

   int n_checks = 0;
   int n_errors = 0;
   mop_t q[$];

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0b expected %0b", nm, act, exp);
      end
   endtask

   task automatic chkw(input string nm, input logic [79:0] act, input logic [79:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();
      disp_v = 1'b0; disp_ir = '0; disp_ip = '0; disp_imm = '0; disp_tgt = '0;
      disp_av = 1'b0; disp_bv = 1'b0; disp_cv = 1'b0;
      disp_at = '0; disp_bt = '0; disp_ct = '0;
      disp_a = '0; disp_b = '0; disp_c = '0;
      rb_v = 1'b0; rb_tag = '0; rb_val = '0; flush = 1'b0;
   endtask

   task automatic drive_disp(input disp_t d);
      disp_v = 1'b1; disp_ir = d.ir; disp_ip = d.ip; disp_imm = d.imm; disp_tgt = d.tgt;
      disp_av = d.av; disp_at = d.at; disp_a = d.a;
      disp_bv = d.bv; disp_bt = d.bt; disp_b = d.b;
      disp_cv = d.cv; disp_ct = d.ct; disp_c = d.c;
   endtask

   function automatic disp_t mk(input logic [31:0] ir, input logic [79:0] a,
                                input logic [79:0] imm, input logic [4:0] tgt);
      disp_t d;
      d = '0;
      d.ir = ir; d.ip = 64'h1000 + 64'(tgt) * 4; d.imm = imm; d.tgt = tgt;
      d.av = 1'b1; d.a = a; d.bv = 1'b1; d.b = a ^ 80'h5A; d.cv = 1'b1; d.c = 80'(tgt);
      return d;
   endfunction

   function automatic logic [79:0] rnd80();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[79:0];
   endfunction

   function automatic mop_t to_mop(input disp_t d);
      mop_t m;
      m.ir = d.ir; m.ip = d.ip; m.imm = d.imm; m.tgt = d.tgt;
      m.ov = {d.cv, d.bv, d.av};
      m.ot[0] = d.at; m.ot[1] = d.bt; m.ot[2] = d.ct;
      m.val[0] = d.a; m.val[1] = d.b; m.val[2] = d.c;
      m.held = 1'b0;
      return m;
   endfunction

   function automatic mop_t wake(input mop_t m, input logic v, input logic [4:0] t,
                                 input logic [79:0] val);
      mop_t r;
      r = m;
      for (int k = 0; k < 3; k++) begin
         if (v && !r.ov[k] && r.ot[k] == t) begin
            r.ov[k] = 1'b1;
            r.val[k] = val;
         end
      end
      return r;
   endfunction

   vec_t tbl[5];

   initial begin
      disp_t d;
      idle();
      rst = 1'b1;
      iss_rdy = 1'b0;

      tbl[0] = '{mk(OP_ADDI, 80'd5, 80'd3, 5'd1), 80'd8};
      tbl[1] = '{mk(OP_ADDI, {80{1'b1}}, 80'd1, 5'd2), 80'd0};
      tbl[2] = '{mk(OP_ADD, 80'd0, 80'd0, 5'd31), 80'd0};
      tbl[3] = '{mk(OP_ADDI, 80'h1_2345_6789, 80'h1000, 5'd17), 80'h1_2345_7789};
      tbl[4] = '{mk(OP_ADD, 80'h8000_0000_0000_0000_0000, 80'h8000_0000_0000_0000_0000, 5'd9), 80'd0};

      // Reset state
      @(negedge clk);
      step();
      #1;
      chk1("rst_disp_rdy", disp_rdy, 1'b0);
      chk1("rst_iss_v", iss_v, 1'b0);
      rst = 1'b0;
      #1;
      chk1("post_rst_disp_rdy", disp_rdy, 1'b1);
      chk1("post_rst_iss_v", iss_v, 1'b0);

      // Vector table: one op through an empty queue, seen one cycle after dispatch
      for (int i = 0; i < 5; i++) begin
         drive_disp(tbl[i].d);
         step();
         idle();
         #1;
         chk1("vec_iss_v", iss_v, 1'b1);
         chkw("vec_iss_a", iss_a, tbl[i].d.a);
         chkw("vec_iss_b", iss_b, tbl[i].d.b);
         chkw("vec_iss_c", iss_c, tbl[i].d.c);
         chkw("vec_iss_imm", iss_imm, tbl[i].d.imm);
         chkw("vec_iss_tgt", 80'(iss_tgt), 80'(tbl[i].d.tgt));
         chkw("vec_iss_ir", 80'(iss_ir), 80'(tbl[i].d.ir));
         chkw("vec_iss_ip", 80'(iss_ip), 80'(tbl[i].d.ip));
         chkw("vec_alu_res", iss_a + iss_imm, tbl[i].exp_res);
         iss_rdy = 1'b1;
         step();
         iss_rdy = 1'b0;
         #1;
         chk1("vec_drained", iss_v, 1'b0);
      end

      // Operand b waits on tag 7, woken by a later broadcast
      d = mk(OP_ADD, 80'd1, 80'd0, 5'd3);
      d.bv = 1'b0; d.bt = 5'd7; d.b = '0;
      drive_disp(d);
      step();
      idle();
      #1;
      chk1("wake_wait_iss_v", iss_v, 1'b0);
      rb_v = 1'b1; rb_tag = 5'd7; rb_val = 80'h10;
      step();
      idle();
      #1;
      chk1("wake_iss_v", iss_v, 1'b1);
      chkw("wake_iss_b", iss_b, 80'h10);
      chkw("wake_iss_a", iss_a, 80'd1);
      iss_rdy = 1'b1;
      step();
      iss_rdy = 1'b0;

      // Fill the queue with the ALU stalled, then release one
      for (int k = 0; k < 4; k++) begin
         drive_disp(mk(OP_ADDI, 80'(10 + k), 80'd0, 5'(k)));
         step();
      end
      idle();
      #1;
      chk1("full_disp_rdy", disp_rdy, 1'b0);
      chkw("full_oldest_a", iss_a, 80'd10);
      iss_rdy = 1'b1;
      step();
      iss_rdy = 1'b0;
      #1;
      chk1("full_reopen_disp_rdy", disp_rdy, 1'b1);
      chkw("full_next_a", iss_a, 80'd11);
      iss_rdy = 1'b1;
      step(); step(); step();
      iss_rdy = 1'b0;
      #1;
      chk1("full_drained_iss_v", iss_v, 1'b0);

      // Broadcast matching disp_bt in the dispatch cycle itself
      d = mk(OP_ADD, 80'd2, 80'd0, 5'd4);
      d.bv = 1'b0; d.bt = 5'd9; d.b = '0;
      drive_disp(d);
      rb_v = 1'b1; rb_tag = 5'd9; rb_val = 80'h55;
      #1;
`ifdef BW_ISSUE_BYPASS_EN
      chk1("samecyc_byp_iss_v", iss_v, 1'b1);
      chkw("samecyc_byp_iss_b", iss_b, 80'h55);
`else
      chk1("samecyc_iss_v", iss_v, 1'b0);
`endif
      step();
      idle();
      #1;
      chk1("samecyc_next_iss_v", iss_v, 1'b1);
      chkw("samecyc_next_iss_b", iss_b, 80'h55);
      iss_rdy = 1'b1;
      step();
      iss_rdy = 1'b0;

      // Stalled selection stays pinned while an older entry wakes
      d = mk(OP_ADD, 80'hA0, 80'd0, 5'd5);
      d.bv = 1'b0; d.bt = 5'd3; d.b = '0;
      drive_disp(d);
      step();
      drive_disp(mk(OP_ADDI, 80'hA1, 80'd1, 5'd6));
      step();
      idle();
      #1;
      chkw("hold_first_a", iss_a, 80'hA1);
      rb_v = 1'b1; rb_tag = 5'd3; rb_val = 80'h33;
      step();
      idle();
      #1;
      chk1("hold_iss_v", iss_v, 1'b1);
      chkw("hold_stable_a", iss_a, 80'hA1);
      chkw("hold_stable_tgt", 80'(iss_tgt), 80'd6);
      iss_rdy = 1'b1;
      step();
      iss_rdy = 1'b0;
      #1;
      chkw("hold_after_a", iss_a, 80'hA0);
      chkw("hold_after_b", iss_b, 80'h33);
      iss_rdy = 1'b1;
      step();
      iss_rdy = 1'b0;
      #1;
      chk1("hold_drained", iss_v, 1'b0);

      // Flush (pass 0) and reset (pass 1) with three entries pending
      for (int pass = 0; pass < 2; pass++) begin
         for (int k = 0; k < 3; k++) begin
            d = mk(OP_ADDI, 80'(32 + k), 80'd0, 5'(20 + k));
            if (k != 0) begin
               d.cv = 1'b0; d.ct = 5'd4;
            end
            drive_disp(d);
            step();
         end
         idle();
         if (pass == 0) begin
            drive_disp(mk(OP_ADDI, 80'd99, 80'd0, 5'd30));
            flush = 1'b1;
            #1;
         end else begin
            rst = 1'b1;
            #1;
            chk1("rst_mid_iss_v", iss_v, 1'b0);
            chk1("rst_mid_disp_rdy", disp_rdy, 1'b0);
            chkw("rst_mid_iss_a", iss_a, 80'd0);
         end
         step();
         idle();
         rst = 1'b0;
         #1;
         chk1("clear_iss_v", iss_v, 1'b0);
         chk1("clear_disp_rdy", disp_rdy, 1'b1);
         rb_v = 1'b1; rb_tag = 5'd4; rb_val = 80'h4;
         iss_rdy = 1'b1;
         for (int k = 0; k < 3; k++) begin
            step();
            #1;
            chk1("clear_no_issue", iss_v, 1'b0);
         end
         idle();
         iss_rdy = 1'b0;
      end

      // Randomized run against an in-order queue model
      q.delete();
      for (int cyc = 0; cyc < 600; cyc++) begin
         mop_t m, e, t;
         int sel;
         bit byp, exp_v, disp_ok, acc;
         d.ir = $urandom; d.ip = {$urandom, $urandom}; d.imm = rnd80();
         d.tgt = 5'($urandom_range(0, 31));
         d.av = 1'($urandom_range(0, 1)); d.at = 5'($urandom_range(0, 7)); d.a = rnd80();
         d.bv = 1'($urandom_range(0, 1)); d.bt = 5'($urandom_range(0, 7)); d.b = rnd80();
         d.cv = 1'($urandom_range(0, 1)); d.ct = 5'($urandom_range(0, 7)); d.c = rnd80();
         drive_disp(d);
         disp_v = ($urandom_range(0, 2) != 0);
         rb_v = ($urandom_range(0, 1) != 0);
         rb_tag = 5'($urandom_range(0, 15));
         rb_val = rnd80();
         flush = ($urandom_range(0, 39) == 0);
         iss_rdy = ($urandom_range(0, 3) != 0);

         m = wake(to_mop(d), rb_v, rb_tag, rb_val);
         sel = -1;
         foreach (q[i]) if (q[i].held) sel = i;
         if (sel < 0) begin
            foreach (q[i]) if (sel < 0 && q[i].ov == 3'b111) sel = i;
         end
         disp_ok = disp_v && (q.size() < NENT) && !flush;
         byp = 1'b0;
`ifdef BW_ISSUE_BYPASS_EN
         byp = (sel < 0) && disp_ok && (m.ov == 3'b111);
`endif
         exp_v = (sel >= 0) || byp;
         e = (sel >= 0) ? q[sel] : m;

         #1;
         chk1("rnd_disp_rdy", disp_rdy, q.size() < NENT);
         chk1("rnd_iss_v", iss_v, exp_v);
         if (exp_v) begin
            chkw("rnd_iss_a", iss_a, e.val[0]);
            chkw("rnd_iss_b", iss_b, e.val[1]);
            chkw("rnd_iss_c", iss_c, e.val[2]);
            chkw("rnd_iss_imm", iss_imm, e.imm);
            chkw("rnd_iss_tgt", 80'(iss_tgt), 80'(e.tgt));
            chkw("rnd_iss_ir", 80'(iss_ir), 80'(e.ir));
            chkw("rnd_iss_ip", 80'(iss_ip), 80'(e.ip));
         end

         if (flush) begin
            q.delete();
         end else begin
            acc = exp_v && iss_rdy;
            foreach (q[i]) q[i] = wake(q[i], rb_v, rb_tag, rb_val);
            if (sel >= 0) begin
               if (acc) begin
                  q.delete(sel);
               end else begin
                  t = q[sel];
                  t.held = 1'b1;
                  q[sel] = t;
               end
            end
            if (disp_ok && !(byp && acc)) begin
               m.held = byp && !iss_rdy;
               q.push_back(m);
            end
         end
         step();
      end
      idle();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
